// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG quantize + zigzag stage.
package jpeg_pkg;

  localparam int COEF_WIDTH  = 16;
  localparam int RECIP_WIDTH = 16;

  typedef logic signed [COEF_WIDTH-1:0] quant_coef_t;

  typedef enum logic [1:0] {
    QZ_IDLE  = 2'd0,
    QZ_RUN   = 2'd1,
    QZ_DRAIN = 2'd2
  } qz_state_t;

  // Natural (row-major) address of each zigzag position.
  localparam logic [5:0] ZIGZAG_TO_NATURAL [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/jpeg_quant_zigzag_if.sv
// Coefficient-buffer read port plus zigzag output stream of the quantizer.
interface jpeg_quant_zigzag_if #(
  parameter int OUT_WIDTH = 12
);
  import jpeg_pkg::*;

  logic [5:0]                  coef_rd_addr;
  logic                        coef_rd_en;
  quant_coef_t                 coef_rd_data;
  logic [RECIP_WIDTH-1:0]      recip_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [5:0]                  out_index;
  logic                        out_last;

  modport master (
    output coef_rd_addr, coef_rd_en, out_valid, out_data, out_index, out_last,
    input  coef_rd_data, recip_data, out_ready
  );

  modport slave (
    input  coef_rd_addr, coef_rd_en, out_valid, out_data, out_index, out_last,
    output coef_rd_data, recip_data, out_ready
  );

endinterface

// File: rtl/quant_stream_fifo.sv
// Small synchronous FIFO buffering quantized coefficients ahead of the stream port.
module quant_stream_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W - 1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(PTR_W + 1){1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + ONE_PTR;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// Quantizes one 8x8 DCT block by reciprocal multiply and streams it in zigzag order.
// Optional feature macro QUANT_NZ_COUNT_EN adds the nz_count AC non-zero counter port.
module jpeg_quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int DCT_SHIFT  = 3,
  parameter int OUT_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef QUANT_NZ_COUNT_EN
  output logic [6:0] nz_count,
`endif
  jpeg_quant_zigzag_if.master bus
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = OUT_WIDTH + 6;
  localparam int SHIFT   = 15 + DCT_SHIFT;
  localparam int PROD_W  = COEF_WIDTH + RECIP_WIDTH + 1;

  localparam logic [PROD_W:0] HALF     = {{PROD_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [PROD_W:0] POS_MAX  = {{(PROD_W + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [PROD_W:0] NEG_MAG  = {{PROD_W{1'b0}}, 1'b1} << (OUT_WIDTH - 1);
  localparam logic signed [OUT_WIDTH-1:0] Q_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = {{(CNT_W - 1){1'b0}}, 1'b1};

  // Round half away from zero on the magnitude, then saturate to the output range.
  function automatic logic signed [OUT_WIDTH-1:0] quantize(input logic signed [PROD_W-1:0] p);
    logic            neg;
    logic [PROD_W:0] mag;
    logic [PROD_W:0] m;
    neg = p[PROD_W-1];
    if (neg) begin
      mag = {(PROD_W + 1){1'b0}} - {p[PROD_W-1], p};
    end else begin
      mag = {1'b0, p};
    end
    m = (mag + HALF) >> SHIFT;
    if (!neg) begin
      if (m > POS_MAX) quantize = Q_MAX;
      else             quantize = $signed(m[OUT_WIDTH-1:0]);
    end else if (m > NEG_MAG) begin
      quantize = Q_MIN;
    end else begin
      quantize = $signed(~m[OUT_WIDTH-1:0] + {{(OUT_WIDTH - 1){1'b0}}, 1'b1});
    end
  endfunction

  qz_state_t                 state_r;
  logic                      busy_r;
  logic [5:0]                zz_rd_r;
  logic [5:0]                zz_out_r;
  logic [CNT_W-1:0]          inflight_r;
  logic                      rd_en_r;
  logic [5:0]                rd_addr_r;
  logic [5:0]                idx0_r;
  logic                      v1_r;
  logic [5:0]                idx1_r;
  logic                      v2_r;
  logic [5:0]                idx2_r;
  logic signed [PROD_W-1:0]  prod_r;
  logic signed [PROD_W-1:0]  coef_x_s;
  logic signed [PROD_W-1:0]  recip_x_s;
  logic                      issue_s;
  logic                      hs_s;
  logic [CNT_W:0]            occupancy_s;
  logic [CNT_W-1:0]          fifo_count_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [ENTRY_W-1:0]        push_data_s;
  logic [ENTRY_W-1:0]        head_s;

  assign occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_r};
  assign hs_s        = bus.out_valid & bus.out_ready;
  assign done        = (state_r == QZ_DRAIN) & hs_s & (zz_out_r == 6'd63);
  assign busy        = busy_r;
  assign coef_x_s    = {{(PROD_W - COEF_WIDTH){bus.coef_rd_data[COEF_WIDTH-1]}}, bus.coef_rd_data};
  assign recip_x_s   = {{(PROD_W - RECIP_WIDTH){1'b0}}, bus.recip_data};
  assign push_data_s = {quantize(prod_r), idx2_r};

  // Reads are only issued when every in-flight result is guaranteed a FIFO slot.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == QZ_RUN) && !fifo_full_s && (occupancy_s < DEPTH_LIM)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Block sequencer: read issue, zigzag counters and busy flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= QZ_IDLE;
      busy_r    <= 1'b0;
      zz_rd_r   <= 6'd0;
      zz_out_r  <= 6'd0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= 6'd0;
      idx0_r    <= 6'd0;
    end else begin
      rd_en_r <= issue_s;
      if (issue_s) begin
        rd_addr_r <= ZIGZAG_TO_NATURAL[zz_rd_r];
        idx0_r    <= zz_rd_r;
      end
      case (state_r)
        QZ_IDLE: begin
          if (start) begin
            state_r  <= QZ_RUN;
            busy_r   <= 1'b1;
            zz_rd_r  <= 6'd0;
            zz_out_r <= 6'd0;
          end
        end
        QZ_RUN: begin
          if (issue_s) begin
            zz_rd_r <= zz_rd_r + 6'd1;
            if (zz_rd_r == 6'd63) state_r <= QZ_DRAIN;
          end
          if (hs_s) zz_out_r <= zz_out_r + 6'd1;
        end
        QZ_DRAIN: begin
          if (hs_s) zz_out_r <= zz_out_r + 6'd1;
          if (done) begin
            state_r <= QZ_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= QZ_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Reads issued but not yet written into the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      case ({issue_s, v2_r})
        2'b10:   inflight_r <= inflight_r + ONE_CNT;
        2'b01:   inflight_r <= inflight_r - ONE_CNT;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Data returns one cycle after the read; the product is registered, then rounded on push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_r   <= 1'b0;
      idx1_r <= 6'd0;
      v2_r   <= 1'b0;
      idx2_r <= 6'd0;
      prod_r <= {PROD_W{1'b0}};
    end else begin
      v1_r   <= rd_en_r;
      idx1_r <= idx0_r;
      v2_r   <= v1_r;
      idx2_r <= idx1_r;
      if (v1_r) prod_r <= coef_x_s * recip_x_s;
    end
  end

  quant_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (v2_r),
    .push_data (push_data_s),
    .pop       (hs_s),
    .pop_data  (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign bus.coef_rd_en   = rd_en_r;
  assign bus.coef_rd_addr = rd_addr_r;
  assign bus.out_valid    = ~fifo_empty_s;
  assign bus.out_data     = head_s[ENTRY_W-1:6];
  assign bus.out_index    = head_s[5:0];
  assign bus.out_last     = ~fifo_empty_s & (head_s[5:0] == 6'd63);

`ifdef QUANT_NZ_COUNT_EN
  logic [6:0] nz_count_r;

  // Non-zero AC outputs of the current block, frozen once the block completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nz_count_r <= 7'd0;
    end else if ((state_r == QZ_IDLE) && start) begin
      nz_count_r <= 7'd0;
    end else if (hs_s && (bus.out_index != 6'd0) && (bus.out_data != {OUT_WIDTH{1'b0}})) begin
      nz_count_r <= nz_count_r + 7'd1;
    end else begin
      nz_count_r <= nz_count_r;
    end
  end

  assign nz_count = nz_count_r;
`endif

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed scoreboard bench for jpeg_quant_zigzag (default parameters, DCT_SHIFT=3).
module tb_jpeg_quant_zigzag;

  localparam int S = 18;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
`ifdef QUANT_NZ_COUNT_EN
  logic [6:0] nz_count;
`endif

  jpeg_quant_zigzag_if #(.OUT_WIDTH(12)) bus_if ();

  jpeg_quant_zigzag dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
`ifdef QUANT_NZ_COUNT_EN
    .nz_count (nz_count),
`endif
    .bus      (bus_if)
  );

  always #5 clock = ~clock;

  int coef_v [64];
  int recip_v [64];
  int zz_tab [64];
  int exp_data [$];
  int exp_idx [$];
  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int last_data = 0;
  int prev_data = 0;
  int prev_idx = 0;
  bit prev_stall = 1'b0;
  int e_d;
  int e_i;

  // Coefficient buffer and quant table, one cycle read latency.
  always @(posedge clock) begin
    if (bus_if.coef_rd_en) begin
      bus_if.coef_rd_data <= 16'(coef_v[bus_if.coef_rd_addr]);
      bus_if.recip_data   <= 16'(recip_v[bus_if.coef_rd_addr]);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_q(input int coef, input int recip);
    longint p, mag, m;
    p   = longint'(coef) * longint'(recip);
    mag = (p < 0) ? -p : p;
    m   = (mag + (longint'(1) << (S - 1))) >> S;
    if (p < 0) m = -m;
    if (m > 2047) m = 2047;
    if (m < -2048) m = -2048;
    return int'(m);
  endfunction

  // Output monitor: scoreboard pops, hold-while-stalled checks, event counters.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", int'(bus_if.out_data), prev_data);
        check("hold_index", int'(bus_if.out_index), prev_idx);
      end
      if (bus_if.coef_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (bus_if.out_valid && bus_if.out_ready) begin
        hs_cnt++;
        check("sb_has_entry", int'(exp_data.size() != 0), 1);
        if (exp_data.size() != 0) begin
          e_d = exp_data.pop_front();
          e_i = exp_idx.pop_front();
          check("out_data", int'(bus_if.out_data), e_d);
          check("out_index", int'(bus_if.out_index), e_i);
          check("out_last", int'(bus_if.out_last), int'(e_i == 63));
          check("done_at_hs", int'(done), int'(e_i == 63));
        end
        last_data = int'(bus_if.out_data);
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = int'(bus_if.out_data);
      prev_idx   = int'(bus_if.out_index);
    end
  end

  task automatic fill_const(input int c, input int r);
    for (int n = 0; n < 64; n++) begin
      coef_v[n]  = c;
      recip_v[n] = r;
    end
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < 64; n++) begin
      coef_v[n]  = 8 * n;
      recip_v[n] = 32768;
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic begin_block();
    for (int z = 0; z < 64; z++) begin
      exp_data.push_back(model_q(coef_v[zz_tab[z]], recip_v[zz_tab[z]]));
      exp_idx.push_back(z);
    end
    pulse_start();
  endtask

  task automatic run_until_idle(input bit toggle, input string tag);
    int n = 0;
    while ((busy === 1'b1 || exp_data.size() != 0) && n < 2000) begin
      @(posedge clock); #1;
      if (toggle) bus_if.out_ready = ~bus_if.out_ready;
      n++;
    end
    bus_if.out_ready = 1'b1;
    check({tag, "_timeout"}, int'(n < 2000), 1);
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n = 0;
    while (hs_cnt < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_wait"}, int'(n < 2000), 1);
  endtask

  task automatic run_block(input string tag, input bit toggle);
    int hs_base   = hs_cnt;
    int done_base = done_cnt;
    begin_block();
    run_until_idle(toggle, tag);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check({tag, "_outputs"}, hs_cnt - hs_base, 64);
  endtask

  int rc [5] = '{800, -800, 896, 832, -832};
  int re [5] = '{6, -6, 7, 7, -7};
  int sc [2] = '{32767, -32768};
  int se [2] = '{2047, -2048};

  initial begin
    int k = 0;
    int rd_base;
    int done_base;
    int hs_base;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_tab[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
          zz_tab[k] = r * 8 + (s - r);
          k++;
        end
      end
    end

    reset = 1'b1;
    start = 1'b0;
    bus_if.out_ready = 1'b1;
    fill_ramp();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(bus_if.coef_rd_en), 0);
    check("rst_rd_addr", int'(bus_if.coef_rd_addr), 0);
    check("rst_valid", int'(bus_if.out_valid), 0);
    check("rst_last", int'(bus_if.out_last), 0);
    check("rst_index", int'(bus_if.out_index), 0);
    check("rst_data", int'(bus_if.out_data), 0);
    @(posedge clock); #1 reset = 1'b0;

    // Identity ramp: output value equals natural address, so order is visible.
    fill_ramp();
    run_block("ident", 1'b0);
    check("ident_last_val", last_data, 63);

    for (int i = 0; i < 5; i++) begin
      fill_const(rc[i], 2048);
      run_block($sformatf("rnd%0d", i), 1'b0);
      check($sformatf("rnd%0d_val", i), last_data, re[i]);
`ifdef QUANT_NZ_COUNT_EN
      if (i == 0) check("nz_count", int'(nz_count), 63);
`endif
    end

    for (int i = 0; i < 2; i++) begin
      fill_const(sc[i], 32768);
      run_block($sformatf("sat%0d", i), 1'b0);
      check($sformatf("sat%0d_val", i), last_data, se[i]);
    end

    // Backpressure: stalled sink, then ready toggling every cycle.
    fill_ramp();
    bus_if.out_ready = 1'b0;
    rd_base   = rd_cnt;
    done_base = done_cnt;
    hs_base   = hs_cnt;
    begin_block();
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("bp_reads_le4", int'((rd_cnt - rd_base) <= 4), 1);
    check("bp_valid", int'(bus_if.out_valid), 1);
    check("bp_no_hs", hs_cnt - hs_base, 0);
    run_until_idle(1'b1, "bp");
    check("bp_done_pulses", done_cnt - done_base, 1);
    check("bp_outputs", hs_cnt - hs_base, 64);

    // Reset after 30 outputs abandons the block.
    fill_ramp();
    done_base = done_cnt;
    hs_base   = hs_cnt;
    begin_block();
    wait_hs(hs_base + 30, "mid");
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("mid_valid", int'(bus_if.out_valid), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    @(posedge clock); #1 reset = 1'b0;
    exp_data.delete();
    exp_idx.delete();
    repeat (3) @(posedge clock);
    check("mid_no_done", done_cnt - done_base, 0);
    for (int n = 0; n < 64; n++) coef_v[n] = 8 * (63 - n);
    run_block("fresh", 1'b0);

    // Start pulse in the middle of a block is ignored.
    fill_ramp();
    done_base = done_cnt;
    hs_base   = hs_cnt;
    begin_block();
    wait_hs(hs_base + 10, "busy_start");
    pulse_start();
    run_until_idle(1'b0, "busy_start");
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("busy_start_done", done_cnt - done_base, 1);
    check("busy_start_outputs", hs_cnt - hs_base, 64);
    check("busy_start_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
